// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller and
// other display blocks that reuse the active-low hex decode table.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_decode
    import seg_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 8-digit seven-segment scan controller: one digit per clk_1k rise,
// anti-ghosting blank gap, leading-zero suppression, per-digit dp and blink.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_TICKS  = 500,
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_1k,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lz_en,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_start
);

    localparam int BCW = $clog2(BLANK_CYCLES + 1);
    localparam int BKW = $clog2(BLINK_TICKS + 1);

    state_t                  state;
    logic                    s1, s2, s3;
    logic                    tick;
    logic [BCW-1:0]          blank_cnt;
    logic [BKW-1:0]          blink_cnt;
    logic                    blink_phase;
    logic [4*NUM_DIGITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic [NUM_DIGITS-1:0]   snap_blink;
    logic                    snap_lz;

    logic [IDX_W-1:0]        next_idx;
    logic [3:0]              cur_nib;
    logic [6:0]              dec_seg;
    logic                    nz_above;
    logic                    lead_zero;
    logic                    suppress;
    logic [NUM_DIGITS-1:0]   an_sel;

    assign tick     = s2 & ~s3;
    assign next_idx = (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
    assign cur_nib  = snap_digits[{digit_idx, 2'b00} +: 4];
    assign an_sel   = ~(NUM_DIGITS'(1) << digit_idx);

    seg7_decode u_decode (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    // A digit is a leading zero only if it and every more significant nibble is zero
    always_comb begin
        nz_above = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(digit_idx) && snap_digits[4*i +: 4] != 4'h0)
                nz_above = 1'b1;
        end
    end

    assign lead_zero = snap_lz && (digit_idx != '0) && !nz_above;
    assign suppress  = (snap_blink[digit_idx] && blink_phase) || lead_zero;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            an          <= '1;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
            frame_start <= 1'b0;
            digit_idx   <= IDX_W'(NUM_DIGITS - 1);
            blank_cnt   <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_blink  <= '0;
            snap_lz     <= 1'b0;
        end else begin
            s1          <= clk_1k;
            s2          <= s1;
            s3          <= s2;
            frame_start <= 1'b0;
            if (tick) begin
                digit_idx <= next_idx;
                an        <= '1;
                seg       <= SEG_OFF;
                dp        <= 1'b1;
                blank_cnt <= BCW'(BLANK_CYCLES - 1);
                state     <= BLANK;
                // Inputs are frozen per frame so mid-frame edits never tear the display
                if (next_idx == '0) begin
                    snap_digits <= digits;
                    snap_dp     <= dp_mask;
                    snap_blink  <= blink_mask;
                    snap_lz     <= lz_en;
                    frame_start <= 1'b1;
                end
                if (blink_cnt == BKW'(BLINK_TICKS - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BKW'(1);
                end
            end else begin
                case (state)
                    BLANK: begin
                        if (blank_cnt == '0) begin
                            state <= SHOW;
                            an    <= suppress ? '1 : an_sel;
                            seg   <= dec_seg;
                            dp    <= ~snap_dp[digit_idx];
                        end else begin
                            blank_cnt <= blank_cnt - BCW'(1);
                        end
                    end
                    IDLE:    state <= IDLE;
                    SHOW:    state <= SHOW;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a reference model feeding a scoreboard queue.
module tb_seg_scan_ctrl;

    localparam int ND = 8;
    localparam int BT = 4;

    logic          clk;
    logic          rst;
    logic          clk_1k;
    logic [31:0]   digits;
    logic [7:0]    dp_mask;
    logic [7:0]    blink_mask;
    logic          lz_en;
    logic [7:0]    an;
    logic [6:0]    seg;
    logic          dp;
    logic [2:0]    digit_idx;
    logic          frame_start;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         idx;
        bit         fs;
        bit         supp;
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } rec_t;

    rec_t sb[$];

    logic [6:0] seg_ref [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int         m_idx;
    int         m_cnt;
    bit         m_phase;
    bit [31:0]  m_dig;
    bit [7:0]   m_dpm;
    bit [7:0]   m_blm;
    bit         m_lz;

    seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .BLANK_CYCLES (16),
        .BLINK_TICKS  (BT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_1k      (clk_1k),
        .digits      (digits),
        .dp_mask     (dp_mask),
        .blink_mask  (blink_mask),
        .lz_en       (lz_en),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .digit_idx   (digit_idx),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_idx   = ND - 1;
        m_cnt   = 0;
        m_phase = 1'b0;
        m_dig   = '0;
        m_dpm   = '0;
        m_blm   = '0;
        m_lz    = 1'b0;
    endtask

    task automatic model_tick();
        rec_t r;
        bit   nz;
        bit   lead;
        m_idx = (m_idx == ND - 1) ? 0 : m_idx + 1;
        r.fs  = (m_idx == 0);
        if (r.fs) begin
            m_dig = digits;
            m_dpm = dp_mask;
            m_blm = blink_mask;
            m_lz  = lz_en;
        end
        if (m_cnt == BT - 1) begin
            m_cnt   = 0;
            m_phase = ~m_phase;
        end else begin
            m_cnt++;
        end
        nz = 1'b0;
        for (int j = m_idx; j < ND; j++)
            if (m_dig[4*j +: 4] != 4'h0) nz = 1'b1;
        lead   = m_lz && (m_idx != 0) && !nz;
        r.idx  = m_idx;
        r.supp = (m_blm[m_idx] && m_phase) || lead;
        r.an   = r.supp ? 8'hFF : ~(8'h01 << m_idx);
        r.seg  = seg_ref[m_dig[4*m_idx +: 4]];
        r.dp   = ~m_dpm[m_idx];
        sb.push_back(r);
    endtask

    task automatic check_blank(input rec_t r);
        chk("idx", 32'(digit_idx), 32'(r.idx));
        chk("frame_start", 32'(frame_start), 32'(r.fs));
        chk("an_blank", 32'(an), 32'hFF);
        chk("seg_blank", 32'(seg), 32'h7F);
        chk("dp_blank", 32'(dp), 32'h1);
    endtask

    task automatic check_show(input rec_t r);
        chk("an_show", 32'(an), 32'(r.an));
        chk("fs_show", 32'(frame_start), 32'h0);
        if (!r.supp) begin
            chk("seg_show", 32'(seg), 32'(r.seg));
            chk("dp_show", 32'(dp), 32'(r.dp));
        end
    endtask

    // One clk_1k period (100 clk): rise, check blank gap and SHOW, fall
    task automatic step();
        rec_t r;
        @(negedge clk) clk_1k = 1'b1;
        model_tick();
        repeat (3) @(posedge clk);
        #1;
        r = sb.pop_front();
        check_blank(r);
        repeat (15) @(posedge clk);
        #1;
        chk("an_hold", 32'(an), 32'hFF);
        @(posedge clk);
        #1;
        check_show(r);
        repeat (30) @(negedge clk);
        clk_1k = 1'b0;
        repeat (50) @(negedge clk);
    endtask

    // Two rises two clk apart: the second lands inside the first blank gap
    task automatic skip_step();
        rec_t ra;
        rec_t rb;
        @(negedge clk) clk_1k = 1'b1;
        model_tick();
        @(negedge clk) clk_1k = 1'b0;
        @(negedge clk) clk_1k = 1'b1;
        model_tick();
        @(posedge clk);
        #1;
        ra = sb.pop_front();
        check_blank(ra);
        repeat (2) @(posedge clk);
        #1;
        rb = sb.pop_front();
        check_blank(rb);
        repeat (15) @(posedge clk);
        #1;
        chk("an_hold_skip", 32'(an), 32'hFF);
        @(posedge clk);
        #1;
        check_show(rb);
        repeat (30) @(negedge clk);
        clk_1k = 1'b0;
        repeat (50) @(negedge clk);
    endtask

    initial begin
        int fs_seen;
        rst        = 1'b0;
        clk_1k     = 1'b0;
        digits     = '0;
        dp_mask    = '0;
        blink_mask = '0;
        lz_en      = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        rst = 1'b1;

        fs_seen = 0;
        repeat (5000) begin
            @(negedge clk);
            if (frame_start) fs_seen++;
        end
        chk("idle_fs_count", 32'(fs_seen), 32'h0);
        chk("idle_an", 32'(an), 32'hFF);
        chk("idle_seg", 32'(seg), 32'h7F);
        chk("idle_dp", 32'(dp), 32'h1);
        chk("idle_idx", 32'(digit_idx), 32'h7);

        digits = 32'h76543210;
        repeat (9) step();

        digits = 32'h00000305;
        lz_en  = 1'b1;
        repeat (16) step();

        digits = 32'h12345678;
        repeat (8) step();
        repeat (3) step();
        digits = 32'h00C0A000;
        repeat (12) step();

        digits     = 32'h9876FEDC;
        lz_en      = 1'b0;
        blink_mask = 8'h11;
        dp_mask    = 8'h02;
        repeat (8) step();
        skip_step();
        repeat (8) step();

        while (m_idx != 5) step();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("rst_an", 32'(an), 32'hFF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_idx", 32'(digit_idx), 32'h7);
        chk("rst_fs", 32'(frame_start), 32'h0);
        model_reset();
        @(negedge clk) rst = 1'b1;
        repeat (5) @(negedge clk);
        digits = 32'h0000ABCD;
        step();
        step();

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
